// File: rtl/sram_dp_param.sv
// rtl/sram_dp_param.sv - parametrised true dual-port SRAM with byte enables, collision flag and clear engine
// Optional feature macro: SRAM_DP_OUTREG_EN adds a second output register stage (read latency 2).
module sram_dp_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WRITE_FIRST = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clearRequest,
  output logic                      busy,
  output logic                      collision,
  input  logic                      enableA,
  input  logic                      enableB,
  input  logic                      writeEnableA,
  input  logic                      writeEnableB,
  input  logic [DATA_WIDTH/8-1:0]   byteEnableA,
  input  logic [DATA_WIDTH/8-1:0]   byteEnableB,
  input  logic [ADDR_WIDTH-1:0]     addressA,
  input  logic [ADDR_WIDTH-1:0]     addressB,
  input  logic [DATA_WIDTH-1:0]     dataInA,
  input  logic [DATA_WIDTH-1:0]     dataInB,
  output logic [DATA_WIDTH-1:0]     dataOutA,
  output logic [DATA_WIDTH-1:0]     dataOutB,
  output logic                      dataValidA,
  output logic                      dataValidB
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run, acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0]   old_a, old_b, merged_a, merged_b, rd_a, rd_b;

  logic [DATA_WIDTH-1:0]   dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic                    dv_a_q, dv_a_d, dv_b_q, dv_b_d;
  logic                    col_q, col_d;

  assign run       = (state_q == S_RUN);
  assign busy      = (state_q == S_CLEAR);
  assign acc_a     = run && enableA;
  assign acc_b     = run && enableB;
  assign wr_a      = acc_a && writeEnableA;
  assign wr_b      = acc_b && writeEnableB;
  assign same_addr = (addressA == addressB);
  assign old_a     = mem[addressA];
  assign old_b     = mem[addressB];

  // Clear engine: counter walks the whole array once, then hands over to normal access
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = S_RUN;
      end
    end else if (clearRequest) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
    end
  end

  // Clear-engine state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Final word at each port's address after both ports' byte-masked writes; A wins shared lanes
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && byteEnableA[i]) begin
        merged_a[8*i +: 8] = dataInA[8*i +: 8];
      end else if (wr_b && same_addr && byteEnableB[i]) begin
        merged_a[8*i +: 8] = dataInB[8*i +: 8];
      end
      if (wr_a && same_addr && byteEnableA[i]) begin
        merged_b[8*i +: 8] = dataInA[8*i +: 8];
      end else if (wr_b && byteEnableB[i]) begin
        merged_b[8*i +: 8] = dataInB[8*i +: 8];
      end
    end
  end

  assign rd_a = (WRITE_FIRST != 0) ? merged_a : old_a;
  assign rd_b = (WRITE_FIRST != 0) ? merged_b : old_b;

  // Array write port: clear engine owns the array while busy, ports otherwise
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_a) begin
        mem[addressA] <= merged_a;
      end
      if (wr_b) begin
        mem[addressB] <= merged_b;
      end
    end
  end

  // Read data, valid strobes and collision flag for the first output stage
  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    dv_a_d   = acc_a;
    dv_b_d   = acc_b;
    col_d    = wr_a && wr_b && same_addr && ((byteEnableA & byteEnableB) != '0);
    if (acc_a) begin
      dout_a_d = rd_a;
    end
    if (acc_b) begin
      dout_b_d = rd_b;
    end
  end

  // First output stage registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
      dv_a_q   <= 1'b0;
      dv_b_q   <= 1'b0;
      col_q    <= 1'b0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      dv_a_q   <= dv_a_d;
      dv_b_q   <= dv_b_d;
      col_q    <= col_d;
    end
  end

`ifdef SRAM_DP_OUTREG_EN
  logic [DATA_WIDTH-1:0]   dout2_a_q, dout2_a_d, dout2_b_q, dout2_b_d;
  logic                    dv2_a_q, dv2_a_d, dv2_b_q, dv2_b_d;
  logic                    col2_q, col2_d;

  // Second stage follows the first in RUN; holds data and suppresses strobes while clearing
  always_comb begin
    dout2_a_d = dout2_a_q;
    dout2_b_d = dout2_b_q;
    dv2_a_d   = 1'b0;
    dv2_b_d   = 1'b0;
    col2_d    = 1'b0;
    if (run) begin
      dout2_a_d = dout_a_q;
      dout2_b_d = dout_b_q;
      dv2_a_d   = dv_a_q;
      dv2_b_d   = dv_b_q;
      col2_d    = col_q;
    end
  end

  // Second output stage registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout2_a_q <= '0;
      dout2_b_q <= '0;
      dv2_a_q   <= 1'b0;
      dv2_b_q   <= 1'b0;
      col2_q    <= 1'b0;
    end else begin
      dout2_a_q <= dout2_a_d;
      dout2_b_q <= dout2_b_d;
      dv2_a_q   <= dv2_a_d;
      dv2_b_q   <= dv2_b_d;
      col2_q    <= col2_d;
    end
  end

  assign dataOutA   = dout2_a_q;
  assign dataOutB   = dout2_b_q;
  assign dataValidA = dv2_a_q;
  assign dataValidB = dv2_b_q;
  assign collision  = col2_q;
`else
  assign dataOutA   = dout_a_q;
  assign dataOutB   = dout_b_q;
  assign dataValidA = dv_a_q;
  assign dataValidB = dv_b_q;
  assign collision  = col_q;
`endif

endmodule
